pulse_period_meter: RTL
=======================

Name: pulse_period_meter

Overview:
Measures the period and high time of an external square wave, counted in `clk` cycles. It is the capture side of the LED period generator. The raw pin is synchronised and glitch-filtered, then timed edge to edge. Results feed the period register of the blink/oscillator logic or a debug readout.

Parameters:
WIDTH, 32, width of period_out/high_out and internal counters
SYNC_STAGES, 2, flip-flops in the input synchroniser (>=2)
FILTER_LEN, 16, consecutive stable cycles required before the filtered level changes (>=1)
TIMEOUT, 96000000, cycles without a filtered rising edge before a measurement is abandoned; elaboration fails if TIMEOUT > 2^WIDTH-1

Ports:
clk  input  1  system clock (48 MHz on board)
reset  input  1  synchronous, active-high reset
sig_in  input  1  asynchronous raw input (button or external oscillator)
clear  input  1  synchronous abort: discard partial measurement, clear timeout
period_out  output  WIDTH  last measured period, cycles between filtered rising edges
high_out  output  WIDTH  last measured high time, cycles
valid  output  1  one-cycle strobe when period_out/high_out update
timeout  output  1  sticky flag: measurement abandoned for lack of edges

Behaviour:
- Reset: period_out=0, high_out=0, valid=0, timeout=0, filtered level=0, state IDLE, all counters 0.
- Synchroniser: sig_in passes through SYNC_STAGES flops; sync stages reset to 0.
- Glitch filter:
  - stab_cnt counts consecutive cycles where the synchronised input differs from filt; it resets to 0 when they match.
  - When the differing condition has held FILTER_LEN cycles, filt toggles and stab_cnt returns to 0.
  - Pulses shorter than FILTER_LEN cycles never reach filt.
  - Delay is constant for clean edges, so measured widths equal the raw widths.
- Edge detect: rise/fall are registered comparisons of filt against filt delayed one cycle.
- State machine:
  - IDLE: wait for a rise; on rise, go to HIGH with per_cnt=1 and hi_cnt=1. No result is produced, because the first edge after reset, clear or timeout only starts timing.
  - HIGH: per_cnt and hi_cnt increment each cycle; on fall, go to LOW (per_cnt keeps counting).
  - LOW: per_cnt increments; on rise, period_out<=per_cnt, high_out<=hi_cnt, valid=1 for that cycle, per_cnt<=1, hi_cnt<=1, go to HIGH.
  - Result: for a clean input with period P and high time H, period_out=P and high_out=H.
- Timeout:
  - Applies in HIGH or LOW. If per_cnt reaches TIMEOUT with no rise, then timeout<=1, go to IDLE, and valid stays 0.
  - period_out/high_out keep their last values.
  - timeout clears on the next valid strobe or on clear.
  - A stuck-high or stuck-low input therefore times out; IDLE itself never times out.
- Counters cannot wrap: TIMEOUT < 2^WIDTH is enforced at elaboration.
- Precedence per cycle: reset > clear > edge/timeout handling.
  - clear in the same cycle as a rise: clear wins, state goes to IDLE, and that edge is not used as a start.
  - clear does not alter period_out/high_out or the filter/synchroniser.
- Latency: a raw rising edge causes valid SYNC_STAGES+FILTER_LEN+1 cycles later (±1 for metastability resolution). Outputs are stable from the valid cycle until the next valid.

Optional Feature:
- Macro: PERIOD_METER_AVG_EN.
- Defined:
  - Completed periods and high times go into 4-entry shift registers.
  - period_out/high_out are the sum of the 4 entries >>2, truncated; sums are carried at WIDTH+2 bits.
  - valid pulses only once 4 results have been captured since the last reset/clear/timeout, then on every subsequent result.
  - clear and timeout empty the history.
- Undefined: every completed period is reported directly, as described above.

Test Plan:
- Reset for 3 cycles with sig_in toggling -> period_out=0, high_out=0, valid=0, timeout=0 throughout and for 1 cycle after release.
- Defaults, clean wave high 30 / low 70 cycles, 5 periods -> first valid after the 2nd rising edge; each valid shows period_out=100, high_out=30; exactly 4 valid strobes, each one cycle wide.
- FILTER_LEN=4, period-100 wave with a 3-cycle low glitch inside the high phase -> the glitch is ignored (period_out=100, high_out=30); a 4-cycle glitch is accepted and yields high_out≠30.
- TIMEOUT=500, one rise then sig_in held high 600 cycles -> timeout=1 at per_cnt=500, no valid, state IDLE; two further rises 100 apart -> valid with period_out=100 and timeout cleared.
- clear asserted mid-LOW, and separately clear coincident with a filtered rise -> no valid for the next rise; the first valid comes one full period after the following rise; previous period_out is retained meanwhile.
- PERIOD_METER_AVG_EN, periods 100,104,96,100 then 120 -> no valid for the first 3 results; 4th valid shows 100; 5th shows (104+96+100+120)>>2=105.

Source files
------------

// File: rtl/pulse_period_meter_if.sv
// Pulse period meter bus: raw input and abort in, measurement results out.
//   sig_in     : raw asynchronous square-wave input
//   clear      : synchronous abort of the measurement in progress
//   period_out : last reported period, clk cycles
//   high_out   : last reported high time, clk cycles
//   valid      : one-cycle strobe when period_out/high_out update
//   timeout    : sticky flag, measurement abandoned for lack of edges
interface pulse_period_meter_if #(
    parameter int unsigned WIDTH = 32
);
    logic             sig_in;
    logic             clear;
    logic [WIDTH-1:0] period_out;
    logic [WIDTH-1:0] high_out;
    logic             valid;
    logic             timeout;

    modport master (
        output sig_in,
        output clear,
        input  period_out,
        input  high_out,
        input  valid,
        input  timeout
    );

    modport slave (
        input  sig_in,
        input  clear,
        output period_out,
        output high_out,
        output valid,
        output timeout
    );
endinterface

// File: rtl/pulse_period_meter.sv
// Pulse period meter: synchronises and glitch-filters a raw square wave,
// then times filtered rising edge to rising edge in clk cycles.
//   clk   : system clock
//   reset : synchronous, active-high reset
//   bus   : pulse_period_meter_if.slave (sig_in, clear in; period_out,
//           high_out, valid, timeout out)
// Optional macro PERIOD_METER_AVG_EN: report the truncated mean of the last
// four completed periods/high times instead of each result directly.
module pulse_period_meter #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILTER_LEN  = 16,
    parameter int unsigned TIMEOUT     = 96000000
) (
    input  logic                clk,
    input  logic                reset,
    pulse_period_meter_if.slave bus
);
    localparam int unsigned FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [FW-1:0]    STAB_LAST = FW'(FILTER_LEN - 1);
    localparam logic [WIDTH-1:0] TMO_CNT   = WIDTH'(TIMEOUT);

    // Elaboration guards: counters must never wrap before the timeout fires.
    if ((WIDTH < 64) && (64'(TIMEOUT) > ((64'd1 << WIDTH) - 64'd1))) begin : g_bad_timeout
        $error("pulse_period_meter: TIMEOUT does not fit in WIDTH bits");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("pulse_period_meter: SYNC_STAGES must be at least 2");
    end
    if ((FILTER_LEN < 1) || (TIMEOUT < 1)) begin : g_bad_len
        $error("pulse_period_meter: FILTER_LEN and TIMEOUT must be at least 1");
    end

    typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW} state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic [FW-1:0]          stab_cnt;
    logic                   filt, filt_d, rise, fall;
    state_t                 state, state_nxt;
    logic [WIDTH-1:0]       per_cnt, hi_cnt;
    logic [WIDTH-1:0]       period_q, high_q;
    logic                   valid_q, timeout_q;
    logic                   at_tmo;
    logic                   start_c, capture_c, tmo_c, cnt_per_c, cnt_hi_c;

    // Input synchroniser.
    always_ff @(posedge clk) begin
        if (reset) sync_q <= '0;
        else       sync_q <= {sync_q[SYNC_STAGES-2:0], bus.sig_in};
    end

    // Glitch filter: filt follows the input only after FILTER_LEN differing cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            filt     <= 1'b0;
            stab_cnt <= '0;
        end else if (sync_q[SYNC_STAGES-1] != filt) begin
            if (stab_cnt == STAB_LAST) begin
                filt     <= ~filt;
                stab_cnt <= '0;
            end else begin
                stab_cnt <= stab_cnt + FW'(1);
            end
        end else begin
            stab_cnt <= '0;
        end
    end

    // Registered edge detect on the filtered level.
    always_ff @(posedge clk) begin
        if (reset) begin
            filt_d <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            filt_d <= filt;
            rise   <= filt & ~filt_d;
            fall   <= ~filt & filt_d;
        end
    end

    assign at_tmo = (per_cnt == TMO_CNT);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next state; clear overrides any edge or timeout.
    always_comb begin
        state_nxt = state;
        if (bus.clear) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (rise) state_nxt = S_HIGH;
                S_HIGH:  if (at_tmo) state_nxt = S_IDLE;
                         else if (fall) state_nxt = S_LOW;
                S_LOW:   if (rise) state_nxt = S_HIGH;
                         else if (at_tmo) state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Per-cycle datapath actions decoded from state and edges.
    always_comb begin
        start_c   = 1'b0;
        capture_c = 1'b0;
        tmo_c     = 1'b0;
        cnt_per_c = 1'b0;
        cnt_hi_c  = 1'b0;
        if (!bus.clear) begin
            case (state)
                S_IDLE: start_c = rise;
                S_HIGH: begin
                    if (at_tmo) begin
                        tmo_c = 1'b1;
                    end else begin
                        cnt_per_c = 1'b1;
                        cnt_hi_c  = ~fall;  // fall cycle already belongs to the low phase
                    end
                end
                S_LOW: begin
                    if (rise)        capture_c = 1'b1;
                    else if (at_tmo) tmo_c     = 1'b1;
                    else             cnt_per_c = 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef PERIOD_METER_AVG_EN
    localparam int unsigned SW = WIDTH + 2;
    // Three stored results plus the one being captured form the 4-entry window.
    logic [2:0][WIDTH-1:0] per_hist, hi_hist;
    logic [1:0]            hist_cnt;
    logic [SW-1:0]         per_sum_c, hi_sum_c;

    always_comb begin
        per_sum_c = SW'(per_cnt) + SW'(per_hist[0]) + SW'(per_hist[1]) + SW'(per_hist[2]);
        hi_sum_c  = SW'(hi_cnt)  + SW'(hi_hist[0])  + SW'(hi_hist[1])  + SW'(hi_hist[2]);
    end
`endif

    // Counters and registered results.
    always_ff @(posedge clk) begin
        if (reset) begin
            per_cnt   <= '0;
            hi_cnt    <= '0;
            period_q  <= '0;
            high_q    <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
`ifdef PERIOD_METER_AVG_EN
            per_hist  <= '0;
            hi_hist   <= '0;
            hist_cnt  <= '0;
`endif
        end else begin
            valid_q <= 1'b0;
            if (bus.clear) begin
                per_cnt   <= '0;
                hi_cnt    <= '0;
                timeout_q <= 1'b0;
`ifdef PERIOD_METER_AVG_EN
                hist_cnt  <= '0;
`endif
            end else if (start_c) begin
                per_cnt <= WIDTH'(1);
                hi_cnt  <= WIDTH'(1);
            end else if (capture_c) begin
                per_cnt <= WIDTH'(1);
                hi_cnt  <= WIDTH'(1);
`ifdef PERIOD_METER_AVG_EN
                per_hist <= {per_hist[1], per_hist[0], per_cnt};
                hi_hist  <= {hi_hist[1], hi_hist[0], hi_cnt};
                if (hist_cnt == 2'd3) begin
                    period_q  <= WIDTH'(per_sum_c >> 2);
                    high_q    <= WIDTH'(hi_sum_c >> 2);
                    valid_q   <= 1'b1;
                    timeout_q <= 1'b0;
                end else begin
                    hist_cnt <= hist_cnt + 2'd1;
                end
`else
                period_q  <= per_cnt;
                high_q    <= hi_cnt;
                valid_q   <= 1'b1;
                timeout_q <= 1'b0;
`endif
            end else if (tmo_c) begin
                per_cnt   <= '0;
                hi_cnt    <= '0;
                timeout_q <= 1'b1;
`ifdef PERIOD_METER_AVG_EN
                hist_cnt  <= '0;
`endif
            end else begin
                if (cnt_per_c) per_cnt <= per_cnt + WIDTH'(1);
                if (cnt_hi_c)  hi_cnt  <= hi_cnt + WIDTH'(1);
            end
        end
    end

    assign bus.period_out = period_q;
    assign bus.high_out   = high_q;
    assign bus.valid      = valid_q;
    assign bus.timeout    = timeout_q;
endmodule
